// File: rtl/network_source_sparse.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | network_source_sparse: SPIKE packets build a charge frame, and a    |
// | COMMIT packet replays it to the network for N run cycles. Rev 1.0   |
// +--------------------------------------------------------------------+
module network_source_sparse #(
  parameter int PKT_WIDTH    = 24,
  parameter int NUM_INP      = 8,
  parameter int CHARGE_WIDTH = 8,
  parameter int RUN_WIDTH    = 8
) (
  input  logic                           clk,
  input  logic                           arstn,
  input  logic                           src_valid,
  output logic                           src_ready,
  input  logic [PKT_WIDTH-1:0]           src,
  input  logic                           net_ready,
  output logic                           net_run,
  output logic                           net_sync,
  output logic                           net_clear,
  output logic signed [CHARGE_WIDTH-1:0] net_inp [0:NUM_INP-1],
  output logic                           idx_err
);
  localparam int IDX_WIDTH = (NUM_INP > 2) ? $clog2(NUM_INP) : 1;

  typedef enum logic [0:0] {ACCUM = 1'b0, FIRE = 1'b1} state_t;

  state_t                         state_q, state_d;
  logic signed [CHARGE_WIDTH-1:0] acc_q [NUM_INP];
  logic signed [CHARGE_WIDTH-1:0] acc_d [NUM_INP];
  logic [RUN_WIDTH-1:0]           remaining_q, remaining_d;
  logic                           sync_q, sync_d;
  logic                           clear_q, clear_d;
  logic                           first_q, first_d;
  logic                           idx_err_q, idx_err_d;

  logic                           w_opcode;
  logic [IDX_WIDTH-1:0]           w_idx;
  logic signed [CHARGE_WIDTH-1:0] w_charge;
  logic [RUN_WIDTH-1:0]           w_run;
  logic                           w_idx_ok;
  logic                           unused_src;

  assign w_opcode   = src[PKT_WIDTH-1];
  assign w_idx      = src[PKT_WIDTH-2 -: IDX_WIDTH];
  assign w_charge   = src[PKT_WIDTH-2-IDX_WIDTH -: CHARGE_WIDTH];
  assign w_run      = src[RUN_WIDTH-1:0];
  assign w_idx_ok   = (int'(w_idx) < NUM_INP);
  assign unused_src = ^src;

  // One extra bit of headroom; disagreeing top bits mean overflow.
  function automatic logic signed [CHARGE_WIDTH-1:0] sat_add(
    input logic signed [CHARGE_WIDTH-1:0] a,
    input logic signed [CHARGE_WIDTH-1:0] b
  );
    logic [CHARGE_WIDTH:0] s;
    s = {a[CHARGE_WIDTH-1], a} + {b[CHARGE_WIDTH-1], b};
    if (s[CHARGE_WIDTH] != s[CHARGE_WIDTH-1])
      sat_add = s[CHARGE_WIDTH] ? {1'b1, {(CHARGE_WIDTH-1){1'b0}}}
                                : {1'b0, {(CHARGE_WIDTH-1){1'b1}}};
    else
      sat_add = s[CHARGE_WIDTH-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    sync_d      = sync_q;
    clear_d     = clear_q;
    first_d     = first_q;
    idx_err_d   = idx_err_q;
    case (state_q)
      ACCUM: begin
        if (src_valid) begin
          if (!w_opcode) begin
            if (!w_idx_ok) idx_err_d = 1'b1;
            for (int i = 0; i < NUM_INP; i++)
              if (w_idx_ok && w_idx == IDX_WIDTH'(i))
                acc_d[i] = sat_add(acc_q[i], w_charge);
          end else begin
            sync_d      = src[PKT_WIDTH-2];
            clear_d     = src[PKT_WIDTH-3];
            remaining_d = (w_run == '0) ? RUN_WIDTH'(1) : w_run;
            first_d     = 1'b1;
            state_d     = FIRE;
          end
        end
      end
      FIRE: begin
        if (net_ready) begin
          if (first_q)
            for (int i = 0; i < NUM_INP; i++) acc_d[i] = '0;
          first_d     = 1'b0;
          remaining_d = remaining_q - RUN_WIDTH'(1);
          if (remaining_q == RUN_WIDTH'(1)) begin
            state_d = ACCUM;
            sync_d  = 1'b0;
            clear_d = 1'b0;
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= ACCUM;
      for (int i = 0; i < NUM_INP; i++) acc_q[i] <= '0;
      remaining_q <= '0;
      sync_q      <= 1'b0;
      clear_q     <= 1'b0;
      first_q     <= 1'b0;
      idx_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      sync_q      <= sync_d;
      clear_q     <= clear_d;
      first_q     <= first_d;
      idx_err_q   <= idx_err_d;
    end
  end

  assign src_ready = (state_q == ACCUM);
  assign net_run   = (state_q == FIRE);
  assign net_sync  = (state_q == FIRE) && (remaining_q == RUN_WIDTH'(1)) && sync_q;
  assign net_clear = (state_q == FIRE) && first_q && clear_q;
  assign idx_err   = idx_err_q;

  generate
    for (genvar g = 0; g < NUM_INP; g++) begin : g_inp
      assign net_inp[g] = ((state_q == FIRE) && first_q) ? acc_q[g] : '0;
    end
  endgenerate
endmodule
`default_nettype wire

// File: tb/tb_network_source_sparse.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_network_source_sparse: directed + random frames vs. frame model  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_network_source_sparse;
  localparam int PW = 24;
  localparam int NI = 6;
  localparam int CW = 8;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          arstn = 1'b0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [PW-1:0] src = '0;
  logic          net_ready = 1'b1;
  logic          net_run;
  logic          net_sync;
  logic          net_clear;
  logic signed [CW-1:0] net_inp [0:NI-1];
  logic          idx_err;

  int checks = 0;
  int errors = 0;
  int acc_m [NI];
  bit err_m;

  always #5 clk = ~clk;

  network_source_sparse #(
    .PKT_WIDTH(PW), .NUM_INP(NI), .CHARGE_WIDTH(CW), .RUN_WIDTH(RW)
  ) dut (
    .clk(clk), .arstn(arstn), .src_valid(src_valid), .src_ready(src_ready),
    .src(src), .net_ready(net_ready), .net_run(net_run), .net_sync(net_sync),
    .net_clear(net_clear), .net_inp(net_inp), .idx_err(idx_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) acc_m[i] = 0;
    err_m = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_src_ready"}, src_ready, 1);
    chk({tag, "_net_run"}, net_run, 0);
    chk({tag, "_net_sync"}, net_sync, 0);
    chk({tag, "_net_clear"}, net_clear, 0);
    for (int i = 0; i < NI; i++) chk({tag, "_net_inp"}, net_inp[i], 0);
  endtask

  // Called at a negedge; returns at the negedge after the packet is taken.
  task automatic send(input logic [PW-1:0] p);
    chk("send_src_ready", src_ready, 1);
    src_valid = 1'b1;
    src = p;
    @(posedge clk);
    @(negedge clk);
    src_valid = 1'b0;
    src = PW'($urandom);
  endtask

  task automatic spike(input int idx, input int ch);
    int s;
    send({1'b0, 3'(idx), 8'(ch), 12'($urandom)});
    if (idx >= NI) err_m = 1'b1;
    else begin
      s = acc_m[idx] + ch;
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      acc_m[idx] = s;
    end
  endtask

  // mode 0: net_ready always high, 1: pattern 1,0,0 repeating, 2: random
  task automatic frame(input bit sync, input bit clear, input int n, input int mode);
    int total;
    int k;
    int c;
    int snap [NI];
    bit r;
    total = (n == 0) ? 1 : n;
    snap = acc_m;
    k = 0;
    c = 0;
    send({1'b1, sync, clear, 13'($urandom), 8'(n)});
    while (k < total && c < 400) begin
      chk("fire_net_run", net_run, 1);
      chk("fire_src_ready", src_ready, 0);
      for (int i = 0; i < NI; i++)
        chk("fire_net_inp", net_inp[i], (k == 0) ? snap[i] : 0);
      chk("fire_net_sync", net_sync, (k == total - 1) && sync);
      chk("fire_net_clear", net_clear, (k == 0) && clear);
      if (mode == 0) r = 1'b1;
      else if (mode == 1) r = (c % 3 == 0);
      else r = 1'($urandom_range(0, 1));
      net_ready = r;
      @(posedge clk);
      @(negedge clk);
      if (r) k++;
      c++;
    end
    chk("transfer_count", k, total);
    net_ready = 1'b1;
    chk("after_src_ready", src_ready, 1);
    chk("after_net_run", net_run, 0);
    chk("idx_err", idx_err, err_m);
    for (int i = 0; i < NI; i++) acc_m[i] = 0;
  endtask

  initial begin
    model_reset();
    // Reset held with random source activity
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      src_valid = 1'($urandom_range(0, 1));
      src = PW'($urandom);
      #1;
      check_idle("reset");
      chk("reset_idx_err", idx_err, 0);
    end
    @(negedge clk);
    src_valid = 1'b0;
    arstn = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    // Accumulate with saturation
    spike(2, 100);
    spike(2, 100);
    spike(5, -3);
    frame(1'b1, 1'b1, 1, 0);

    // Multi-cycle run, then same with backpressure
    spike(0, 7);
    frame(1'b1, 1'b0, 4, 0);
    spike(0, 7);
    frame(1'b1, 1'b0, 4, 1);

    // N=0 on empty frame, then another empty frame
    frame(1'b0, 1'b0, 0, 0);
    frame(1'b0, 1'b1, 2, 0);

    // Bad index, sticky flag
    spike(7, 5);
    chk("idx_err_set", idx_err, 1);
    frame(1'b0, 1'b0, 1, 0);
    spike(1, 3);
    spike(6, -9);
    frame(1'b1, 1'b1, 2, 2);

    // Negative saturation
    spike(3, -100);
    spike(3, -100);
    spike(4, 127);
    spike(4, -1);
    frame(1'b0, 1'b1, 3, 2);

    // Reset mid-run drops the frame
    spike(1, 50);
    send({1'b1, 1'b1, 1'b1, 13'd0, 8'd5});
    net_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrun_running", net_run, 1);
    #2;
    arstn = 1'b0;
    #1;
    check_idle("midrun_reset");
    chk("midrun_idx_err", idx_err, 0);
    model_reset();
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    frame(1'b0, 1'b0, 1, 0);

    // Random frames
    for (int f = 0; f < 30; f++) begin
      int ns;
      ns = $urandom_range(0, 6);
      for (int s = 0; s < ns; s++)
        spike($urandom_range(0, 7), $urandom_range(0, 255) - 128);
      frame(1'($urandom), 1'($urandom), $urandom_range(0, 6), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
